pc_gen_stage: RTL and testbench

//  Next-PC generator sitting directly upstream of IF. Holds the PC to issue, offers it to IF

---
 rtl/pc_gen_stage_pkg.sv | 22 ++
 rtl/pc_gen_stage.sv | 95 +++++++++
 tb/tb_pc_gen_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_stage_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_stage_pkg
//   Shared definitions for the next-PC generator: the power-on PC and the
//   two sequencing states.
//   SEQ      : next PC after an issue is pc_r + 4
//   DS_PEND  : pc_r is an unissued delay slot, tgt_r holds the branch target
// ---------------------------------------------------------------------------
package pc_gen_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;

    typedef enum logic {
        SEQ     = 1'b0,
        DS_PEND = 1'b1
    } pcg_state_e;

    // Sequential successor; 32-bit add wraps naturally (fffffffc -> 00000000).
    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_gen_stage.sv
// ---------------------------------------------------------------------------
// pc_gen_stage
//   Next-PC generator upstream of IF. Offers pc_o with a valid/ready
//   handshake, advances by 4 on each accepted issue, and applies redirects
//   from CP0 (flush) and from ID (taken branch, honouring the delay slot).
//   Wrong-path issues are not killed here; ID drops them by PC mismatch.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   ready_i              IF accepts pc_o this cycle
//   valid_o, pc_o        fetch request to IF
//   br_valid_i/taken_i   branch resolved in ID / resolved taken
//   br_pc_i, br_target_i PC of the branch and its target
//   flush_i, flush_pc_i  exception entry / ERET and redirect target
//   cancel_o             cancel to IF, mirrors flush_i combinationally
//   ds_pending_o         a taken target waits behind the unissued delay slot
// ---------------------------------------------------------------------------
module pc_gen_stage
    import pc_gen_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_pc_i,
    input  logic [31:0] br_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        cancel_o,
    output logic        ds_pending_o
);

    logic [31:0] pc_r;
    logic [31:0] tgt_r;
    pcg_state_e  state;
    logic        started_r;

    logic        issue;
    logic        br_take;
    logic        ds_unissued;

    assign valid_o      = started_r && !flush_i;
    assign pc_o         = pc_r;
    assign cancel_o     = flush_i;
    assign ds_pending_o = (state == DS_PEND);

    assign issue       = valid_o && ready_i;
    assign br_take     = br_valid_i && br_taken_i;
    // pc_r is the branch's delay slot and has not left yet.
    assign ds_unissued = (pc_r == pc_next_seq(br_pc_i));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r      <= RESET_PC;
            tgt_r     <= '0;
            state     <= SEQ;
            started_r <= 1'b0;
        end else begin
            started_r <= 1'b1;
            if (flush_i) begin
                pc_r  <= flush_pc_i;
                state <= SEQ;
            end else if (br_take) begin
                if (ds_unissued || state == DS_PEND) begin
                    // Delay slot still owed to IF. A branch seen while already
                    // pending (branch in a delay slot) just replaces the target.
                    if (issue) begin
                        pc_r  <= br_target_i;
                        state <= SEQ;
                    end else begin
                        tgt_r <= br_target_i;
                        state <= DS_PEND;
                    end
                end else begin
                    // Delay slot already gone; any issue now is wrong-path.
                    pc_r  <= br_target_i;
                    state <= SEQ;
                end
            end else if (issue) begin
                if (state == DS_PEND) begin
                    pc_r  <= tgt_r;
                    state <= SEQ;
                end else begin
                    pc_r <= pc_next_seq(pc_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_stage.sv
// ---------------------------------------------------------------------------
// tb_pc_gen_stage
//   Directed bench: issued PCs are checked against a queue of expected
//   values filled by the stimulus; state/output checks are inline.
// ---------------------------------------------------------------------------
module tb_pc_gen_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        br_valid_i;
    logic        br_taken_i;
    logic [31:0] br_pc_i;
    logic [31:0] br_target_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        cancel_o;
    logic        ds_pending_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pc_gen_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .br_valid_i   (br_valid_i),
        .br_taken_i   (br_taken_i),
        .br_pc_i      (br_pc_i),
        .br_target_i  (br_target_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .cancel_o     (cancel_o),
        .ds_pending_o (ds_pending_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [31:0] bpc, input logic [31:0] tgt);
        br_valid_i  = 1'b1;
        br_taken_i  = 1'b1;
        br_pc_i     = bpc;
        br_target_i = tgt;
    endtask

    task automatic no_branch();
        br_valid_i = 1'b0;
        br_taken_i = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] fpc);
        flush_i    = 1'b1;
        flush_pc_i = fpc;
        cyc();
        flush_i = 1'b0;
    endtask

    // Scoreboard: every accepted issue must match the next expected PC.
    always @(negedge clk) begin
        if (resetn && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_issue: got %h expected none", pc_o);
            end else begin
                chk("issue_pc", pc_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        resetn = 1'b0; ready_i = 1'b1; flush_i = 1'b0; flush_pc_i = '0;
        br_valid_i = 1'b0; br_taken_i = 1'b0; br_pc_i = '0; br_target_i = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_ds", {31'd0, ds_pending_o}, 32'd0);
        chk("rst_pc", pc_o, 32'hbfc00000);

        // 1: release, first cycle not valid, then sequential issue
        resetn = 1'b1;
        @(negedge clk);
        chk("first_valid", {31'd0, valid_o}, 32'd0);
        cyc();
        exp_q.push_back(32'hbfc00000); exp_q.push_back(32'hbfc00004);
        exp_q.push_back(32'hbfc00008); exp_q.push_back(32'hbfc0000c);
        exp_q.push_back(32'hbfc00010);
        repeat (5) cyc();
        chk("seq_pc", pc_o, 32'hbfc00014);

        // 2: taken branch, delay slot not issued, IF stalled -> DS_PEND
        ready_i = 1'b0;
        branch(32'hbfc00010, 32'hbfc00100);
        cyc();
        no_branch();
        chk("ds_set", {31'd0, ds_pending_o}, 32'd1);
        chk("ds_hold_pc", pc_o, 32'hbfc00014);
        chk("stall_valid", {31'd0, valid_o}, 32'd1);
        exp_q.push_back(32'hbfc00014);
        ready_i = 1'b1;
        cyc();
        ready_i = 1'b0;
        chk("ds_tgt_pc", pc_o, 32'hbfc00100);
        chk("ds_clear", {31'd0, ds_pending_o}, 32'd0);

        // Flush: combinational cancel, no issue
        flush_i = 1'b1; flush_pc_i = 32'hbfc00014;
        #1;
        chk("flush_cancel", {31'd0, cancel_o}, 32'd1);
        chk("flush_valid", {31'd0, valid_o}, 32'd0);
        cyc();
        flush_i = 1'b0;
        chk("flush_pc", pc_o, 32'hbfc00014);

        // 3: same branch, delay slot issues in the same cycle
        ready_i = 1'b1;
        exp_q.push_back(32'hbfc00014);
        branch(32'hbfc00010, 32'hbfc00100);
        cyc();
        no_branch(); ready_i = 1'b0;
        chk("br_issue_pc", pc_o, 32'hbfc00100);
        chk("br_issue_ds", {31'd0, ds_pending_o}, 32'd0);

        // 4: delay slot already issued; wrong-path issue goes out unmodified
        do_flush(32'hbfc00018);
        ready_i = 1'b1;
        exp_q.push_back(32'hbfc00018);
        branch(32'hbfc00010, 32'h80001000);
        cyc();
        no_branch(); ready_i = 1'b0;
        chk("late_br_pc", pc_o, 32'h80001000);
        chk("late_br_ds", {31'd0, ds_pending_o}, 32'd0);

        // 5: flush beats a simultaneous taken branch
        ready_i = 1'b1;
        flush_i = 1'b1; flush_pc_i = 32'hbfc00380;
        branch(32'h80000ffc, 32'h12345678);
        #1;
        chk("fb_cancel", {31'd0, cancel_o}, 32'd1);
        chk("fb_valid", {31'd0, valid_o}, 32'd0);
        cyc();
        flush_i = 1'b0; no_branch(); ready_i = 1'b0;
        #1;
        chk("fb_pc", pc_o, 32'hbfc00380);
        chk("fb_ds", {31'd0, ds_pending_o}, 32'd0);
        chk("fb_cancel_off", {31'd0, cancel_o}, 32'd0);

        // Not-taken branch has no effect
        br_valid_i = 1'b1; br_taken_i = 1'b0;
        br_pc_i = 32'hbfc0037c; br_target_i = 32'h00000500;
        cyc();
        no_branch();
        chk("nt_pc", pc_o, 32'hbfc00380);
        chk("nt_ds", {31'd0, ds_pending_o}, 32'd0);

        // 6: wraparound
        do_flush(32'hfffffffc);
        ready_i = 1'b1;
        exp_q.push_back(32'hfffffffc);
        cyc();
        ready_i = 1'b0;
        chk("wrap_pc", pc_o, 32'h00000000);

        // Branch in delay slot: newest target wins
        branch(32'hfffffffc, 32'h00000040);
        cyc();
        branch(32'hfffffffc, 32'h00000080);
        cyc();
        no_branch();
        chk("ovw_ds", {31'd0, ds_pending_o}, 32'd1);
        chk("ovw_hold", pc_o, 32'h00000000);
        ready_i = 1'b1;
        exp_q.push_back(32'h00000000);
        cyc();
        ready_i = 1'b0;
        chk("ovw_tgt", pc_o, 32'h00000080);

        // Async reset while DS_PEND
        branch(32'h0000007c, 32'h00000200);
        cyc();
        no_branch();
        chk("pre_rst_ds", {31'd0, ds_pending_o}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_pc", pc_o, 32'hbfc00000);
        chk("async_valid", {31'd0, valid_o}, 32'd0);
        chk("async_ds", {31'd0, ds_pending_o}, 32'd0);

        cyc();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
